// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the mem-stage to split-transaction bus bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Partial-word lane patterns (0111/1110 from lwl/lwr/swl/swr) travel as word accesses.
    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        logic [1:0] size;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            4'b0011, 4'b1100:                   size = SIZE_H;
            default:                            size = SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Converts the single-cycle mem-stage data access into a req/addr_ok/data_ok bus
// transaction, stalling the pipeline until the access completes.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // byte lanes are fixed, so this must stay 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stallreq_o,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [3:0]        data_wstrb_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    state_e            state_reg;
    logic              discard_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        sel_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic issue;
    logic resp_ok;

    always_comb begin
        issue   = (state_reg == ST_IDLE) && mem_ce_i && !flush_i;
        // A response is only forwarded when it belongs to a live instruction.
        resp_ok = (state_reg == ST_WAIT) && data_data_ok_i && !discard_reg && !flush_i;
    end

    always_comb begin
        mem_rdata_o  = '0;
        stallreq_o   = 1'b0;
        data_req_o   = 1'b0;
        data_wr_o    = 1'b0;
        data_size_o  = SIZE_B;
        data_wstrb_o = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    stallreq_o = mem_ce_i;
                    if (issue) begin
                        data_req_o   = 1'b1;
                        data_wr_o    = mem_we_i;
                        data_size_o  = sel_to_size(mem_sel_i);
                        data_wstrb_o = mem_sel_i;
                        data_addr_o  = mem_addr_i;
                        data_wdata_o = mem_wdata_i;
                    end
                end
                ST_REQ: begin
                    stallreq_o   = 1'b1;
                    data_req_o   = 1'b1;
                    data_wr_o    = we_reg;
                    data_size_o  = sel_to_size(sel_reg);
                    data_wstrb_o = sel_reg;
                    data_addr_o  = addr_reg;
                    data_wdata_o = wdata_reg;
                end
                ST_WAIT: begin
                    stallreq_o = !(data_data_ok_i && !discard_reg);
                    if (resp_ok && !we_reg) begin
                        mem_rdata_o = data_rdata_i;
                    end
                end
                ST_HOLD: begin
                    mem_rdata_o = hold_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            discard_reg <= 1'b0;
            hold_reg    <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            sel_reg     <= 4'b0000;
            wdata_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        we_reg      <= mem_we_i;
                        addr_reg    <= mem_addr_i;
                        sel_reg     <= mem_sel_i;
                        wdata_reg   <= mem_wdata_i;
                        discard_reg <= 1'b0;
                        state_reg   <= data_addr_ok_i ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The request is already visible on the bus and cannot be withdrawn.
                    if (flush_i) begin
                        discard_reg <= 1'b1;
                    end
                    if (data_addr_ok_i) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok_i) begin
                        discard_reg <= 1'b0;
                        if (resp_ok && stall_i) begin
                            hold_reg  <= we_reg ? '0 : data_rdata_i;
                            state_reg <= ST_HOLD;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else if (flush_i) begin
                        discard_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i || flush_i) begin
                        hold_reg  <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the mem stage.
- Turns its single-cycle data-memory request (ce/we/sel/addr/data, read data expected the same cycle) into a split-transaction SRAM-like bus with req/addr_ok/data_ok handshakes.
- Raises a stall request to the pipeline controller until the access completes.
- Holds returned read data while the pipeline is stalled for other reasons, and discards accesses that are flushed while in flight.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width. Must be 32, because the byte lanes below are fixed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_ce_i  in  1  access valid from mem stage
- mem_we_i  in  1  1 = store
- mem_addr_i  in  ADDR_W  byte address (already word-aligned by mem stage for lwl/lwr/swl/swr)
- mem_sel_i  in  4  byte-lane select; bit3 = bits[31:24] = lowest address
- mem_wdata_i  in  DATA_W  store data, already lane-positioned
- stall_i  in  1  mem stage is held this cycle (from the pipeline controller)
- flush_i  in  1  kill the current mem-stage instruction
- mem_rdata_o  out  DATA_W  load data to mem stage
- stallreq_o  out  1  stall request to the pipeline controller
- data_req_o  out  1  bus request
- data_wr_o  out  1  bus write
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb_o  out  4  lane strobes, same encoding as mem_sel_i
- data_addr_o  out  ADDR_W  bus address
- data_wdata_o  out  DATA_W  bus write data
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  response; at most one outstanding
- data_rdata_i  in  DATA_W  read data, valid with data_data_ok_i

Behaviour:
Reset and size
- While rst = 1: all outputs 0, state IDLE, discard flag 0, hold register 0.
- Size from mem_sel_i:
  - one lane set -> 0
  - 0011 or 1100 -> 1
  - anything else nonzero -> 2 (covers 0111 and 1110)
- Address and strobes are passed unchanged.

States: IDLE, REQ, WAIT, HOLD
- IDLE:
  - If mem_ce_i and not flush_i: drive data_req_o = 1 combinationally from the inputs this cycle.
  - addr_ok = 1 -> WAIT. addr_ok = 0 -> latch the request -> REQ.
- REQ:
  - Drive data_req_o = 1 with the latched fields; hold them stable until addr_ok.
  - addr_ok = 1 -> WAIT.
- WAIT:
  - data_req_o = 0; wait for data_ok.
  - On data_ok with discard = 0:
    - stall_i = 0 -> IDLE.
    - stall_i = 1 -> capture data_rdata_i into the hold register -> HOLD.
  - On data_ok with discard = 1 -> IDLE, clear discard, no result.
- HOLD:
  - Leave for IDLE on the first cycle with stall_i = 0.
  - No new request is issued in HOLD.

stallreq_o
- IDLE: equals mem_ce_i.
- REQ: 1.
- WAIT: 1, except 0 in the data_ok cycle when discard = 0.
- HOLD: 0.

mem_rdata_o
- data_rdata_i in the non-discarded WAIT data_ok cycle.
- The hold register in HOLD.
- Otherwise 0.
- For stores: always 0.

Latency
- Best case (addr_ok same cycle, data_ok next cycle): 1 stall cycle.
- There is no combinational path from data_ok to data_req_o.

Flush
- IDLE: no request is issued.
- REQ: the request cannot be withdrawn. Keep req asserted and set discard.
- WAIT: set discard.
- HOLD: go to IDLE.
- With discard set, a new mem_ce_i must wait, with stallreq_o = 1, until the discarded data_ok returns and the bridge is back in IDLE.

Simultaneous events
- flush_i together with data_ok in WAIT: the data is dropped; next state IDLE.
- Reset in any state: the bridge abandons the outstanding transaction. The bus is reset by the same rst.

Decomposition:
- Shared package:
  - state enum (IDLE/REQ/WAIT/HOLD)
  - size constants SIZE_B/H/W
  - sel-to-size function
- No sub-module. A single FSM plus request and hold registers is sufficient.

Test Plan:
- LW @0x100, mem_ce_i = 1, addr_ok same cycle, data_ok +2 with rdata 0xDEADBEEF:
  - Bus sees req = 1, size = 2, wstrb = 1111.
  - stallreq_o = 1 for 2 cycles, 0 in the data_ok cycle.
  - mem_rdata_o = 0xDEADBEEF in that cycle.
- SB @0x103, sel 0001, wdata 0x5A5A5A5A, addr_ok delayed 3 cycles:
  - req held with constant addr/wstrb/wdata through REQ.
  - size = 0, wr = 1.
  - stallreq_o drops on data_ok.
- LH @0x202, data_ok 0x12345678 while stall_i = 1 for 2 more cycles:
  - Enters HOLD; mem_rdata_o stays 0x12345678.
  - stallreq_o = 0; no new req until stall_i = 0.
- flush_i in WAIT, then new LW @0x300 next cycle:
  - No req for 0x300 until the old data_ok arrives.
  - Old data is not forwarded; then req for 0x300 issues.
- SWL @0x401 (mem stage gives addr 0x400, sel 0111):
  - size = 2, addr = 0x400, wstrb = 0111.
- rst asserted in REQ:
  - Next cycle all outputs 0, state IDLE.
  - A subsequent LW issues normally.
